// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and counter sizing.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    // Bits needed to count 0 .. max(a,b,c)-1; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high clear.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of an asynchronous level into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL/MMCM reset sequencer: pulses the PLL reset, qualifies LOCKED, and releases
// the downstream system reset only after a sustained lock; retries then faults.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 7
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    pll_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             locked_s;

    sync_2ff u_lock_sync (
        .clk   (clk_in),
        .reset (reset),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Sequencer; outputs are loaded with the values of the state being entered.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r       <= ST_HOLD;
            cnt_r         <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle takes priority over a retry.
                    if (locked_s) begin
                        state_r <= ST_STABLE;
                        cnt_r   <= '0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_r   <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt == RETRY_LIMIT) begin
                            state_r <= ST_FAULT;
                            fault   <= 1'b1;
                        end else begin
                            state_r   <= ST_HOLD;
                            retry_cnt <= retry_cnt + 4'd1;
                        end
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r   <= ST_RUN;
                        cnt_r     <= '0;
                        sys_rst   <= 1'b0;
                        ready     <= 1'b1;
                        retry_cnt <= 4'd0;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    cnt_r <= '0;
                    if (!locked_s) begin
                        state_r <= ST_HOLD;
                        pll_rst <= 1'b1;
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end else begin
                            lock_loss_cnt <= lock_loss_cnt;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FAULT: begin
                    cnt_r   <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                    fault   <= 1'b1;
                end
                default: begin
                    // Unreachable encodings park the block safely in FAULT.
                    state_r <= ST_FAULT;
                    cnt_r   <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                    fault   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with small timing parameters (4/32/8/2).
module tb_pll_reset_ctrl;

    localparam int HOLD   = 4;
    localparam int TMO    = 32;
    localparam int STABLE = 8;
    localparam int RETRY  = 2;
    localparam int LIMIT  = 200;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int vec_cnt = 0;
    int miscompares = 0;
    int n;

    pll_reset_ctrl #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_TIMEOUT       (TMO),
        .LOCK_STABLE_CYCLES (STABLE),
        .MAX_RETRIES        (RETRY)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_vec(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Samples (including the current one) while pll_rst stays at lvl.
    task automatic count_pll_rst(input logic lvl, output int cnt);
        cnt = 0;
        while (pll_rst === lvl && cnt < LIMIT) begin
            cnt++;
            tick();
        end
    endtask

    task automatic count_until_ready(output int cnt);
        cnt = 0;
        while (ready !== 1'b1 && cnt < LIMIT) begin
            tick();
            cnt++;
        end
    endtask

    task automatic count_until_sys_rst(output int cnt);
        cnt = 0;
        while (sys_rst !== 1'b1 && cnt < LIMIT) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_pll_rst"}, int'(pll_rst), 1);
        check_vec({tag, "_sys_rst"}, int'(sys_rst), 1);
        check_vec({tag, "_ready"}, int'(ready), 0);
        check_vec({tag, "_fault"}, int'(fault), 0);
        check_vec({tag, "_retry"}, int'(retry_cnt), 0);
        check_vec({tag, "_lloss"}, int'(lock_loss_cnt), 0);
    endtask

    // Drop lock from RUN, then expect sys_rst 3 cycles later and a 4-cycle PLL reset.
    task automatic lose_lock(input string tag);
        int c;
        pll_locked = 1'b0;
        count_until_sys_rst(c);
        check_vec({tag, "_sysrst_lat"}, c, 3);
        count_pll_rst(1'b1, c);
        check_vec({tag, "_pllrst_w"}, c, HOLD);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_reset_vals("rst");

        // Nominal bring-up
        reset = 1'b0;
        count_pll_rst(1'b1, n);
        check_vec("nom_pllrst_w", n, HOLD);
        repeat (10) tick();
        pll_locked = 1'b1;
        count_until_ready(n);
        check_vec("nom_ready_lat", n, 11);
        check_vec("nom_sys_rst", int'(sys_rst), 0);
        check_vec("nom_retry", int'(retry_cnt), 0);
        check_vec("nom_pll_rst", int'(pll_rst), 0);

        // Lock loss in RUN, then relock
        lose_lock("loss1");
        check_vec("loss1_cnt", int'(lock_loss_cnt), 1);
        check_vec("loss1_ready", int'(ready), 0);
        pll_locked = 1'b1;
        count_until_ready(n);
        check_vec("loss1_relock", n, 11);

        // One-cycle glitch after 5 stable cycles restarts qualification
        lose_lock("glitch");
        pll_locked = 1'b1;
        repeat (7) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        count_until_ready(n);
        check_vec("glitch_ready_lat", n, 11);
        check_vec("glitch_lloss", int'(lock_loss_cnt), 2);

        // Reset while in STABLE
        lose_lock("pre_stable");
        pll_locked = 1'b1;
        repeat (5) tick();
        check_vec("stable_ready", int'(ready), 0);
        reset = 1'b1;
        tick();
        check_reset_vals("rst_stable");
        pll_locked = 1'b0;
        repeat (2) tick();

        // Lock arrives on the timeout cycle: no retry
        reset = 1'b0;
        count_pll_rst(1'b1, n);
        check_vec("sim_hold1", n, HOLD);
        count_pll_rst(1'b0, n);
        check_vec("sim_wait1", n, TMO);
        check_vec("sim_retry1", int'(retry_cnt), 1);
        count_pll_rst(1'b1, n);
        check_vec("sim_hold2", n, HOLD);
        repeat (29) tick();
        pll_locked = 1'b1;
        repeat (3) tick();
        check_vec("sim_no_hold", int'(pll_rst), 0);
        check_vec("sim_retry_kept", int'(retry_cnt), 1);
        count_until_ready(n);
        check_vec("sim_ready_lat", n, 8);
        check_vec("sim_retry_clr", int'(retry_cnt), 0);

        // Never locks: three pulses, then FAULT until reset
        pll_locked = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            count_pll_rst(1'b1, n);
            check_vec($sformatf("nl_hold%0d", i), n, HOLD);
            count_pll_rst(1'b0, n);
            check_vec($sformatf("nl_wait%0d", i), n, TMO);
            check_vec($sformatf("nl_retry%0d", i), int'(retry_cnt), (i < 2) ? i + 1 : 2);
            check_vec($sformatf("nl_fault%0d", i), int'(fault), (i == 2) ? 1 : 0);
        end
        pll_locked = 1'b1;
        repeat (60) tick();
        check_vec("fault_hold", int'(fault), 1);
        check_vec("fault_pll_rst", int'(pll_rst), 1);
        check_vec("fault_sys_rst", int'(sys_rst), 1);
        check_vec("fault_ready", int'(ready), 0);
        reset = 1'b1;
        tick();
        check_reset_vals("rst_fault");

        // 300 lock losses saturate the counter at 255
        reset = 1'b0;
        count_until_ready(n);
        check_vec("sat_first_ready", int'(ready), 1);
        for (int i = 0; i < 300; i++) begin
            int c;
            pll_locked = 1'b0;
            count_until_sys_rst(c);
            pll_locked = 1'b1;
            count_until_ready(c);
            if (i == 0) check_vec("sat_cnt1", int'(lock_loss_cnt), 1);
            if (i == 254) check_vec("sat_cnt255", int'(lock_loss_cnt), 255);
        end
        check_vec("sat_cnt_final", int'(lock_loss_cnt), 255);
        check_vec("sat_ready", int'(ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
